// File: rtl/img_stream_framer.sv
// Image-stream framer for the SD write path: header words, thumbnailed pixels
// (little-endian), optional Fletcher-32 checksum, then zero padding to a block boundary.
module img_stream_framer #(
    parameter int ImageWidth      = 2304,
    parameter int ImageHeight     = 1296,
    parameter int FilterPeriod    = 1,
    parameter int FilterKeep      = 1,
    parameter int HeaderWordCount = 16,
    parameter int ChecksumEn      = 1,
    parameter int PadBlockWords   = 256,
    localparam int HdrIdxW        = (HeaderWordCount > 1) ? $clog2(HeaderWordCount) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [HdrIdxW-1:0] hdr_idx,
    input  logic [15:0]        hdr_word,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [15:0]        pix_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_data
);

    localparam int XW = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
    localparam int YW = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;
    localparam int PW = (FilterPeriod > 1) ? $clog2(FilterPeriod) : 1;
    localparam int PadW = (PadBlockWords > 1) ? $clog2(PadBlockWords) : 1;
    localparam int OutPixCount = (ImageWidth * FilterKeep / FilterPeriod) *
                                 (ImageHeight * FilterKeep / FilterPeriod);
    localparam int TotalWords = HeaderWordCount + OutPixCount + 2 * ChecksumEn;
    localparam int PadCount = (PadBlockWords - TotalWords % PadBlockWords) % PadBlockWords;

    localparam logic [XW-1:0]      XLast   = XW'(ImageWidth - 1);
    localparam logic [YW-1:0]      YLast   = YW'(ImageHeight - 1);
    localparam logic [PW-1:0]      PhLast  = PW'(FilterPeriod - 1);
    localparam logic [PW:0]        KeepLim = (PW + 1)'(FilterKeep);
    localparam logic [PadW-1:0]    PadLast = PadW'(PadCount - 1);
    localparam logic [HdrIdxW-1:0] HdrLast = HdrIdxW'(HeaderWordCount - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_HEADER, ST_PIXELS, ST_CSUM0, ST_CSUM1, ST_PAD, ST_DONE
    } state_t;

    state_t              state_r;
    logic [XW-1:0]       x_cnt_r;
    logic [YW-1:0]       y_cnt_r;
    logic [PW-1:0]       x_ph_r;
    logic [PW-1:0]       y_ph_r;
    logic [PadW-1:0]     pad_cnt_r;
    logic [HdrIdxW-1:0]  hdr_idx_r;
    logic [15:0]         s1_r;
    logic [15:0]         s2_r;
    logic                fin_r;
    logic                busy_r;
    logic                done_r;
    logic                out_valid_r;
    logic [15:0]         out_data_r;

    logic                keep_s;
    logic                load_ok_s;
    logic                load_s;
    logic [15:0]         load_word_s;
    logic                upd_sum_s;
    logic [15:0]         sum_d_s;
    logic                pix_ready_s;
    logic                pix_fire_s;
    logic [15:0]         s1_nxt_s;
    logic [15:0]         s2_nxt_s;

    // Mod-65535 add; 17-bit sum with one conditional subtract, so 65535 folds to 0.
    function automatic logic [15:0] fletcher_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= 17'h0FFFF) begin
            t = t - 17'h0FFFF;
        end else begin
            t = t;
        end
        return t[15:0];
    endfunction

    // Decide whether the output register loads this cycle and with what word.
    always_comb begin
        keep_s      = ({1'b0, x_ph_r} < KeepLim) && ({1'b0, y_ph_r} < KeepLim);
        load_ok_s   = !fin_r && (!out_valid_r || out_ready);
        load_s      = 1'b0;
        load_word_s = 16'h0000;
        upd_sum_s   = 1'b0;
        sum_d_s     = 16'h0000;
        pix_ready_s = 1'b0;
        case (state_r)
            ST_HEADER: begin
                if (load_ok_s) begin
                    load_s      = 1'b1;
                    load_word_s = hdr_word;
                    upd_sum_s   = 1'b1;
                    sum_d_s     = {hdr_word[7:0], hdr_word[15:8]};
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_PIXELS: begin
                if (fin_r) begin
                    pix_ready_s = 1'b0;
                end else if (keep_s) begin
                    pix_ready_s = load_ok_s;
                    if (pix_valid && load_ok_s) begin
                        load_s      = 1'b1;
                        load_word_s = {pix_data[7:0], pix_data[15:8]};
                        upd_sum_s   = 1'b1;
                        sum_d_s     = pix_data;
                    end else begin
                        load_s = 1'b0;
                    end
                end else begin
                    pix_ready_s = 1'b1;
                end
            end
            ST_CSUM0: begin
                if (load_ok_s) begin
                    load_s      = 1'b1;
                    load_word_s = {s1_r[7:0], s1_r[15:8]};
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_CSUM1: begin
                if (load_ok_s) begin
                    load_s      = 1'b1;
                    load_word_s = {s2_r[7:0], s2_r[15:8]};
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_PAD: begin
                if (load_ok_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
        pix_fire_s = pix_valid && pix_ready_s;
        s1_nxt_s   = fletcher_add(s1_r, sum_d_s);
        s2_nxt_s   = fletcher_add(s2_r, s1_nxt_s);
    end

    // Frame sequencer, counters, checksum and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            x_cnt_r     <= {XW{1'b0}};
            y_cnt_r     <= {YW{1'b0}};
            x_ph_r      <= {PW{1'b0}};
            y_ph_r      <= {PW{1'b0}};
            pad_cnt_r   <= {PadW{1'b0}};
            hdr_idx_r   <= {HdrIdxW{1'b0}};
            s1_r        <= 16'h0000;
            s2_r        <= 16'h0000;
            fin_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 16'h0000;
        end else begin
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= load_word_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (upd_sum_s) begin
                s1_r <= s1_nxt_s;
                s2_r <= s2_nxt_s;
            end
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        x_cnt_r   <= {XW{1'b0}};
                        y_cnt_r   <= {YW{1'b0}};
                        x_ph_r    <= {PW{1'b0}};
                        y_ph_r    <= {PW{1'b0}};
                        pad_cnt_r <= {PadW{1'b0}};
                        hdr_idx_r <= {HdrIdxW{1'b0}};
                        s1_r      <= 16'h0000;
                        s2_r      <= 16'h0000;
                        fin_r     <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (load_s) begin
                        hdr_idx_r <= hdr_idx_r + HdrIdxW'(1);
                        if (hdr_idx_r == HdrLast) begin
                            state_r <= ST_PIXELS;
                        end
                    end
                end
                ST_PIXELS: begin
                    if (pix_fire_s) begin
                        if (x_cnt_r == XLast) begin
                            x_cnt_r <= {XW{1'b0}};
                            x_ph_r  <= {PW{1'b0}};
                            if (y_cnt_r == YLast) begin
                                y_cnt_r <= {YW{1'b0}};
                                y_ph_r  <= {PW{1'b0}};
                                if (ChecksumEn != 0) begin
                                    state_r <= ST_CSUM0;
                                end else if (PadCount != 0) begin
                                    state_r <= ST_PAD;
                                end else begin
                                    fin_r <= 1'b1;
                                end
                            end else begin
                                y_cnt_r <= y_cnt_r + YW'(1);
                                y_ph_r  <= (y_ph_r == PhLast) ? {PW{1'b0}} : y_ph_r + PW'(1);
                            end
                        end else begin
                            x_cnt_r <= x_cnt_r + XW'(1);
                            x_ph_r  <= (x_ph_r == PhLast) ? {PW{1'b0}} : x_ph_r + PW'(1);
                        end
                    end
                end
                ST_CSUM0: begin
                    if (load_s) begin
                        state_r <= ST_CSUM1;
                    end
                end
                ST_CSUM1: begin
                    if (load_s) begin
                        if (PadCount != 0) begin
                            state_r <= ST_PAD;
                        end else begin
                            fin_r <= 1'b1;
                        end
                    end
                end
                ST_PAD: begin
                    if (load_s) begin
                        if (pad_cnt_r == PadLast) begin
                            fin_r <= 1'b1;
                        end else begin
                            pad_cnt_r <= pad_cnt_r + PadW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            // Every word is loaded; finish once the last one has left the register.
            if (fin_r && (!out_valid_r || out_ready)) begin
                fin_r   <= 1'b0;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                state_r <= ST_DONE;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign hdr_idx   = hdr_idx_r;
    assign pix_ready = pix_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_img_stream_framer.sv
// Directed bench for img_stream_framer: three parameterisations run from one
// linear stimulus sequence, with hand-computed word streams.
module tb_img_stream_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   vecs = 0;
    int   errs = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- instance A: 4x4, period 2 keep 1, 2 header words, pad 16
    logic        a_start, a_busy, a_done, a_pix_valid, a_pix_ready, a_out_valid, a_out_ready;
    logic [0:0]  a_hdr_idx;
    logic [15:0] a_hdr_word, a_pix_data, a_out_data;
    int          a_idx = 0;
    int          a_base = 0;
    logic        a_fire = 1'b0;
    logic [15:0] a_q[$];
    int          a_dones = 0;
    int          a_last_acc = 0;
    int          a_done_cyc = 0;
    logic        a_chk_stall = 1'b0;
    logic        a_stall_prev = 1'b0;
    logic [15:0] a_prev_data = 16'h0000;

    assign a_hdr_word = (a_hdr_idx == 1'b0) ? 16'hCAFE : 16'hBABE;
    assign a_pix_data = 16'h0100 + 16'(a_idx - a_base);

    img_stream_framer #(.ImageWidth(4), .ImageHeight(4), .FilterPeriod(2), .FilterKeep(1),
                        .HeaderWordCount(2), .ChecksumEn(1), .PadBlockWords(16)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .hdr_idx(a_hdr_idx), .hdr_word(a_hdr_word), .pix_valid(a_pix_valid),
        .pix_ready(a_pix_ready), .pix_data(a_pix_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data));

    // ---------------- instance B: 2x2 unfiltered, header 0xFFFF, zero pixels, pad 8
    logic        b_start, b_busy, b_done, b_pix_ready, b_out_valid;
    logic [0:0]  b_hdr_idx;
    logic [15:0] b_out_data;
    logic [15:0] b_q[$];
    int          b_dones = 0;

    img_stream_framer #(.ImageWidth(2), .ImageHeight(2), .FilterPeriod(1), .FilterKeep(1),
                        .HeaderWordCount(1), .ChecksumEn(1), .PadBlockWords(8)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .hdr_idx(b_hdr_idx), .hdr_word(16'hFFFF), .pix_valid(1'b1),
        .pix_ready(b_pix_ready), .pix_data(16'h0000), .out_valid(b_out_valid),
        .out_ready(1'b1), .out_data(b_out_data));

    // ---------------- instance C: 2x2, no checksum, T = 8 = block, so no padding
    logic        c_start, c_busy, c_done, c_pix_ready, c_out_valid;
    logic [1:0]  c_hdr_idx;
    logic [15:0] c_hdr_word, c_pix_data, c_out_data;
    int          c_idx = 0;
    logic        c_fire = 1'b0;
    logic [15:0] c_q[$];
    int          c_dones = 0;
    int          c_last_acc = 0;
    int          c_done_cyc = 0;

    assign c_hdr_word = 16'hA000 + {14'h0000, c_hdr_idx};
    assign c_pix_data = 16'h0100 + 16'(c_idx);

    img_stream_framer #(.ImageWidth(2), .ImageHeight(2), .FilterPeriod(1), .FilterKeep(1),
                        .HeaderWordCount(4), .ChecksumEn(0), .PadBlockWords(8)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
        .hdr_idx(c_hdr_idx), .hdr_word(c_hdr_word), .pix_valid(1'b1),
        .pix_ready(c_pix_ready), .pix_data(c_pix_data), .out_valid(c_out_valid),
        .out_ready(1'b1), .out_data(c_out_data));

    function automatic logic a_kept(input int i);
        return (i >= 0) && (i < 16) && (((i % 4) % 2) == 0) && (((i / 4) % 2) == 0);
    endfunction

    // pixel sources advance after each accepted pixel
    always @(negedge clk) begin
        a_fire <= a_pix_valid && a_pix_ready;
        c_fire <= c_pix_ready;
    end
    always @(posedge clk) begin
        if (a_fire) a_idx <= a_idx + 1;
        if (c_fire) c_idx <= c_idx + 1;
    end

    // output monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            a_q.push_back(a_out_data);
            a_last_acc <= cyc;
        end
        if (a_done) begin
            a_dones    <= a_dones + 1;
            a_done_cyc <= cyc;
        end
        if (a_chk_stall && a_stall_prev) begin
            chk("stall_hold_valid", 32'(a_out_valid), 32'd1);
            chk("stall_hold_data", 32'(a_out_data), 32'(a_prev_data));
        end
        if (a_chk_stall && a_pix_ready && a_kept(a_idx - a_base))
            chk("kept_pix_ready_gated", 32'(a_out_valid && !a_out_ready), 32'd0);
        a_stall_prev <= a_out_valid && !a_out_ready;
        a_prev_data  <= a_out_data;

        if (b_out_valid) b_q.push_back(b_out_data);
        if (b_done) b_dones <= b_dones + 1;

        if (c_out_valid) begin
            c_q.push_back(c_out_data);
            c_last_acc <= cyc;
        end
        if (c_done) begin
            c_dones    <= c_dones + 1;
            c_done_cyc <= cyc;
        end
    end

    logic [15:0] a_exp [16];
    logic [15:0] b_exp [8];
    logic [15:0] c_exp [8];
    logic [3:0]  pat;
    int          a_qbase;
    int          d0;

    task automatic cmp_a(input string tag, input int qbase);
        chk({tag, "_count"}, 32'(a_q.size() - qbase), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (qbase + i < a_q.size())
                chk($sformatf("%s_w%0d", tag, i), 32'(a_q[qbase + i]), 32'(a_exp[i]));
            else
                chk($sformatf("%s_w%0d_missing", tag, i), 32'd0, 32'd1);
        end
    endtask

    initial begin
        a_exp = '{16'hCAFE, 16'hBABE, 16'h0001, 16'h0201, 16'h0801, 16'h0A01, 16'h99C1, 16'h87BC,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        b_exp = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        c_exp = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'h0001, 16'h0101, 16'h0201, 16'h0301};
        pat = 4'b1001;
        rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_pix_valid = 1'b1;
        a_out_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_pix_ready", 32'(a_pix_ready), 32'd0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data", 32'(a_out_data), 32'd0);
        chk("rst_hdr_idx", 32'(a_hdr_idx), 32'd0);

        // frame 1 on all three instances, out_ready held high
        @(posedge clk); #1;
        rst = 1'b0;
        a_qbase = a_q.size();
        a_start = 1'b1; b_start = 1'b1; c_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        for (int i = 0; i < 300 && (a_dones < 1 || b_dones < 1 || c_dones < 1); i++) @(posedge clk);
        repeat (2) @(negedge clk);
        chk("a1_done_count", 32'(a_dones), 32'd1);
        cmp_a("a1", a_qbase);
        chk("a1_done_after_last", 32'(a_done_cyc - a_last_acc), 32'd1);
        chk("a1_busy_after", 32'(a_busy), 32'd0);
        chk("b_done_count", 32'(b_dones), 32'd1);
        chk("b_count", 32'(b_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < b_q.size(); i++)
            chk($sformatf("b_w%0d", i), 32'(b_q[i]), 32'(b_exp[i]));
        chk("c_done_count", 32'(c_dones), 32'd1);
        chk("c_count", 32'(c_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < c_q.size(); i++)
            chk($sformatf("c_w%0d", i), 32'(c_q[i]), 32'(c_exp[i]));
        chk("c_done_after_last_pixel", 32'(c_done_cyc - c_last_acc), 32'd1);

        // frame 2 on A: out_ready 1,0,0,1 and stray start pulses while busy
        a_base = a_idx;
        a_qbase = a_q.size();
        d0 = a_dones;
        a_chk_stall = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b1;
        for (int i = 0; i < 400 && a_dones == d0; i++) begin
            @(posedge clk); #1;
            a_out_ready = pat[i % 4];
            a_start = (i == 8 || i == 20);
        end
        a_start = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_chk_stall = 1'b0;
        cmp_a("a2", a_qbase);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("a2_single_done", 32'(a_dones - d0), 32'd1);
        chk("a2_no_extra_words", 32'(a_q.size() - a_qbase), 32'd16);
        chk("a2_busy_after", 32'(a_busy), 32'd0);

        // reset in the middle of Pixels with a word pending
        a_base = a_idx;
        d0 = a_dones;
        @(posedge clk); #1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        for (int i = 0; i < 50 && (a_idx - a_base) < 1; i++) begin
            @(posedge clk); #1;
        end
        a_out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_out_valid", 32'(a_out_valid), 32'd1);
        @(negedge clk);
        chk("post_rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("post_rst_busy", 32'(a_busy), 32'd0);
        chk("post_rst_pix_ready", 32'(a_pix_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        a_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_no_partial_done", 32'(a_dones - d0), 32'd0);

        // full frame after the abort
        a_base = a_idx;
        a_qbase = a_q.size();
        @(posedge clk); #1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        for (int i = 0; i < 300 && a_dones == d0; i++) @(posedge clk);
        repeat (2) @(negedge clk);
        chk("a3_done_count", 32'(a_dones - d0), 32'd1);
        cmp_a("a3", a_qbase);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
